id_ex_fwd_stage: RTL

- ID/EX pipeline register for the 5-stage core.
- Captures decoded operands and control from ID, and precomputes the registered 2-bit forwarding selects consumed by the two EX operand forwarding muxes.
- Forwarding-select encoding: 00 = current (ID/EX value), 01 = MEM/WB value, 10 = EX/MEM value.
- Also detects load-use hazards, raises a stall toward IF/ID, and inserts bubbles on stall or flush.

---
 rtl/id_ex_fwd_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_fwd_stage.sv
// -----------------------------------------------------------------------------
// id_ex_fwd_stage
//
// ID/EX pipeline register for the 5-stage core. It captures the decoded
// operands and control from ID. It also precomputes the registered 2-bit
// forwarding selects used by the two EX operand muxes. It detects load-use
// hazards and inserts bubbles.
//
// Forwarding select encoding (fwd_a_sel / fwd_b_sel):
//   00 = current ID/EX value, 01 = MEM/WB value, 10 = EX/MEM value (11 unused)
//
// Valid semantics: id_valid marks a real instruction in ID. ex_valid marks a
// real instruction in EX. A cycle with ex_valid = 0 is a bubble, and every
// registered field is zero in a bubble. stall is a combinational request to
// hold PC and IF/ID for one cycle. While stall is high, this stage loads a
// bubble, so the held ID instruction is accepted on the following edge.
//
// Optional feature (macro ID_EX_WB_BYPASS_EN): when defined, a MEM/WB write to
// a source register replaces the register-file read data on capture. This is
// for register files without write-first behaviour. When undefined, the wb_*
// ports are present but ignored.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   id_*                        decoded instruction from ID
//   flush                       kill the ID instruction (branch/jump)
//   ex_mem_rd/ex_mem_reg_write  destination of the instruction in EX/MEM
//   wb_rd/wb_reg_write/wb_data  write-back port of MEM/WB
//   stall                       load-use stall toward IF/ID (combinational)
//   ex_*                        registered ID/EX contents
//   fwd_a_sel/fwd_b_sel         registered forwarding selects
// -----------------------------------------------------------------------------
module id_ex_fwd_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  localparam logic [1:0] SEL_CUR = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic              ex_rd_nz;
  logic              mem_rd_nz;
  logic              bubble;
  logic [1:0]        sel_a_nxt;
  logic [1:0]        sel_b_nxt;
  logic [DATA_W-1:0] rs_cap;
  logic [DATA_W-1:0] rt_cap;

  assign ex_rd_nz  = (ex_rd != '0);
  assign mem_rd_nz = (ex_mem_rd != '0);

  // Both sources are compared whatever the instruction format. This is
  // conservative: an unused rt can cause a spurious one-cycle stall.
  // flush masks the stall because the killed instruction never needs its
  // operands.
  assign stall = id_valid & ~flush & ex_valid & ex_mem_read & ex_rd_nz &
                 ((ex_rd == id_rs) | (ex_rd == id_rt));

  assign bubble = stall | flush | ~id_valid;

  // The select is resolved one cycle early. The instruction now in EX will sit
  // in EX/MEM when the ID instruction reaches EX, so it maps to 10. The
  // instruction now in EX/MEM will sit in MEM/WB, so it maps to 01. The
  // younger producer wins.
  always_comb begin
    sel_a_nxt = SEL_CUR;
    if (ex_valid & ex_reg_write & ex_rd_nz & (ex_rd == id_rs))
      sel_a_nxt = SEL_MEM;
    else if (ex_mem_reg_write & mem_rd_nz & (ex_mem_rd == id_rs))
      sel_a_nxt = SEL_WB;
  end

  always_comb begin
    sel_b_nxt = SEL_CUR;
    if (ex_valid & ex_reg_write & ex_rd_nz & (ex_rd == id_rt))
      sel_b_nxt = SEL_MEM;
    else if (ex_mem_reg_write & mem_rd_nz & (ex_mem_rd == id_rt))
      sel_b_nxt = SEL_WB;
  end

`ifdef ID_EX_WB_BYPASS_EN
  always_comb begin
    rs_cap = id_rs_data;
    rt_cap = id_rt_data;
    if (wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs)) rs_cap = wb_data;
    if (wb_reg_write & (wb_rd != '0) & (wb_rd == id_rt)) rt_cap = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_reg_write, wb_data};
  assign rs_cap = id_rs_data;
  assign rt_cap = id_rt_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      fwd_a_sel    <= SEL_CUR;
      fwd_b_sel    <= SEL_CUR;
    end else if (bubble) begin
      ex_valid     <= 1'b0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      fwd_a_sel    <= SEL_CUR;
      fwd_b_sel    <= SEL_CUR;
    end else begin
      ex_valid     <= 1'b1;
      ex_rs_data   <= rs_cap;
      ex_rt_data   <= rt_cap;
      ex_imm       <= id_imm;
      ex_ctrl      <= id_ctrl;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      fwd_a_sel    <= sel_a_nxt;
      fwd_b_sel    <= sel_b_nxt;
    end
  end

endmodule
